// File: rtl/hilo_pkg.sv
// Shared types and decode for the HI/LO multiply unit.
// HILO_DIV_EN adds the DIV state and decodes DIV/DIVU as ours.
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
`ifdef HILO_DIV_EN
        , DIV
`endif
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_MULT,
        OP_MULTU,
        OP_MADD,
        OP_MADDU,
        OP_MSUB,
        OP_MSUBU,
        OP_MUL,
        OP_DIV,
        OP_DIVU,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO
    } op_e;

    // SPECIAL-space function codes
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1a;
    localparam logic [5:0] FUNC_DIVU  = 6'h1b;

    // SPECIAL2-space function codes
    localparam logic [5:0] FUNC_MADD  = 6'h00;
    localparam logic [5:0] FUNC_MADDU = 6'h01;
    localparam logic [5:0] FUNC_MUL   = 6'h02;
    localparam logic [5:0] FUNC_MSUB  = 6'h04;
    localparam logic [5:0] FUNC_MSUBU = 6'h05;

    function automatic op_e func_to_op(input logic aluOp, input logic mulOp,
                                       input logic [5:0] func);
        op_e op;
        op = OP_NONE;
        if (aluOp) begin
            case (func)
                FUNC_MULT:  op = OP_MULT;
                FUNC_MULTU: op = OP_MULTU;
                FUNC_MFHI:  op = OP_MFHI;
                FUNC_MFLO:  op = OP_MFLO;
                FUNC_MTHI:  op = OP_MTHI;
                FUNC_MTLO:  op = OP_MTLO;
`ifdef HILO_DIV_EN
                FUNC_DIV:   op = OP_DIV;
                FUNC_DIVU:  op = OP_DIVU;
`endif
                default:    op = OP_NONE;
            endcase
        end else if (mulOp) begin
            case (func)
                FUNC_MADD:  op = OP_MADD;
                FUNC_MADDU: op = OP_MADDU;
                FUNC_MSUB:  op = OP_MSUB;
                FUNC_MSUBU: op = OP_MSUBU;
                FUNC_MUL:   op = OP_MUL;
                default:    op = OP_NONE;
            endcase
        end
        return op;
    endfunction

    function automatic logic isMulOp(input op_e op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
    endfunction

    function automatic logic isSignedOp(input op_e op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV};
    endfunction

    function automatic logic isSubOp(input op_e op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier; done is held while the finished product waits
// for one cycle after the last iteration.
module mul_iter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned Iters = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CntW  = $clog2(Iters + 1);

    logic [2*WIDTH-1:0] accQ;
    logic [2*WIDTH-1:0] mcandQ;
    logic [WIDTH-1:0]   mplierQ;
    logic [CntW-1:0]    cntQ;
    logic               runQ;
    logic [2*WIDTH-1:0] partial;

    always_comb begin
        partial = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (mplierQ[i]) partial = partial + (mcandQ << i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accQ    <= '0;
            mcandQ  <= '0;
            mplierQ <= '0;
            cntQ    <= '0;
            runQ    <= 1'b0;
        end else if (start) begin
            accQ    <= '0;
            mcandQ  <= {{WIDTH{1'b0}}, a};
            mplierQ <= b;
            cntQ    <= CntW'(Iters);
            runQ    <= 1'b1;
        end else if (runQ) begin
            if (cntQ != '0) begin
                accQ    <= accQ + partial;
                mcandQ  <= mcandQ << BITS_PER_CYCLE;
                mplierQ <= mplierQ >> BITS_PER_CYCLE;
                cntQ    <= cntQ - CntW'(1);
            end else begin
                runQ    <= 1'b0;
            end
        end
    end

    assign done    = runQ && (cntQ == '0);
    assign product = accQ;

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage multiply/HI-LO unit: FSM, sign fix-up, accumulate, HI/LO and stall.
// Define HILO_DIV_EN to add the restoring DIV/DIVU path.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ALUOp,
    input  logic             MULOp,
    input  logic [5:0]       Func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Stall,
    output logic [WIDTH-1:0] Res,
    output logic             ResValid,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_e             stateQ;
    op_e                op;
    op_e                opQ;
    logic               ours;
    logic               signQ;
    logic [WIDTH-1:0]   hiQ, loQ, resQ;
    logic               resValidQ;
    logic [2*WIDTH-1:0] pQ;
    logic [WIDTH-1:0]   opA, opB;
    logic               mulStart, mulDone;
    logic [2*WIDTH-1:0] product, pFix;

    assign op    = func_to_op(ALUOp, MULOp, Func);
    assign ours  = (op != OP_NONE);
    assign Stall = (stateQ != IDLE) && ours;

    // Magnitudes for signed ops; the sign is re-applied once the iteration finishes
    assign opA = (isSignedOp(op) && A[WIDTH-1]) ? -A : A;
    assign opB = (isSignedOp(op) && B[WIDTH-1]) ? -B : B;

    assign mulStart = (stateQ == IDLE) && isMulOp(op);
    assign pFix     = signQ ? -product : product;

    mul_iter #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (mulStart),
        .a       (opA),
        .b       (opB),
        .done    (mulDone),
        .product (product)
    );

`ifdef HILO_DIV_EN
    localparam int unsigned DivCntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   divQuotQ, divRemQ, divisorQ, divARawQ;
    logic [DivCntW-1:0] divCntQ;
    logic               quotNegQ, remNegQ, divZeroQ;
    logic [WIDTH:0]     divShift, divTrial;
    logic [WIDTH-1:0]   divNextRem, divNextQuot;

    // One restoring step: shift in the next dividend bit, keep the difference if no borrow
    assign divShift    = {divRemQ, divQuotQ[WIDTH-1]};
    assign divTrial    = divShift - {1'b0, divisorQ};
    assign divNextRem  = divTrial[WIDTH] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
    assign divNextQuot = {divQuotQ[WIDTH-2:0], ~divTrial[WIDTH]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= IDLE;
            opQ       <= OP_NONE;
            signQ     <= 1'b0;
            hiQ       <= '0;
            loQ       <= '0;
            resQ      <= '0;
            resValidQ <= 1'b0;
            pQ        <= '0;
`ifdef HILO_DIV_EN
            divQuotQ  <= '0;
            divRemQ   <= '0;
            divisorQ  <= '0;
            divARawQ  <= '0;
            divCntQ   <= '0;
            quotNegQ  <= 1'b0;
            remNegQ   <= 1'b0;
            divZeroQ  <= 1'b0;
`endif
        end else begin
            resValidQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (ours) begin
                        case (op)
                            OP_MFHI: begin
                                resQ      <= hiQ;
                                resValidQ <= 1'b1;
                            end
                            OP_MFLO: begin
                                resQ      <= loQ;
                                resValidQ <= 1'b1;
                            end
                            OP_MTHI: hiQ <= A;
                            OP_MTLO: loQ <= A;
`ifdef HILO_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                divQuotQ <= opA;
                                divRemQ  <= '0;
                                divisorQ <= opB;
                                divARawQ <= A;
                                divCntQ  <= DivCntW'(WIDTH);
                                quotNegQ <= (op == OP_DIV) && (A[WIDTH-1] ^ B[WIDTH-1]);
                                remNegQ  <= (op == OP_DIV) && A[WIDTH-1];
                                divZeroQ <= (B == '0);
                                stateQ   <= DIV;
                            end
`endif
                            default: begin
                                opQ    <= op;
                                signQ  <= isSignedOp(op) && (A[WIDTH-1] ^ B[WIDTH-1]);
                                stateQ <= MUL;
                            end
                        endcase
                    end
                end
                MUL: begin
                    if (mulDone) begin
                        case (opQ)
                            OP_MULT, OP_MULTU: begin
                                {hiQ, loQ} <= pFix;
                                stateQ     <= IDLE;
                            end
                            OP_MUL: begin
                                resQ      <= pFix[WIDTH-1:0];
                                resValidQ <= 1'b1;
                                stateQ    <= IDLE;
                            end
                            default: begin
                                pQ     <= pFix;
                                stateQ <= ACC;
                            end
                        endcase
                    end
                end
                ACC: begin
                    {hiQ, loQ} <= isSubOp(opQ) ? ({hiQ, loQ} - pQ) : ({hiQ, loQ} + pQ);
                    stateQ     <= IDLE;
                end
`ifdef HILO_DIV_EN
                DIV: begin
                    divQuotQ <= divNextQuot;
                    divRemQ  <= divNextRem;
                    divCntQ  <= divCntQ - DivCntW'(1);
                    if (divCntQ == DivCntW'(1)) begin
                        loQ    <= divZeroQ ? '1 : (quotNegQ ? -divNextQuot : divNextQuot);
                        hiQ    <= divZeroQ ? divARawQ : (remNegQ ? -divNextRem : divNextRem);
                        stateQ <= IDLE;
                    end
                end
`endif
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign Res      = resQ;
    assign ResValid = resValidQ;
    assign HI       = hiQ;
    assign LO       = loQ;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: expected Res values are queued at issue and popped by a
// monitor on every ResValid; HI/LO are mostly observed through MFHI/MFLO.
module tb_hilo_unit;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_MADD  = 6'h00;
    localparam logic [5:0] F_MUL   = 6'h02;
    localparam logic [5:0] F_MSUB  = 6'h04;

    logic         clk = 1'b0;
    logic         rst;
    logic         ALUOp, MULOp;
    logic [5:0]   Func;
    logic [W-1:0] A, B, Res, HI, LO;
    logic         Stall, ResValid;

    int           passCnt  = 0;
    int           checkCnt = 0;
    logic [W-1:0] expQ[$];
    string        nameQ[$];
    logic [W-1:0] monExp;
    string        monName;
    int           s;

    hilo_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .ALUOp    (ALUOp),
        .MULOp    (MULOp),
        .Func     (Func),
        .A        (A),
        .B        (B),
        .Stall    (Stall),
        .Res      (Res),
        .ResValid (ResValid),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expectRes(input string name, input logic [W-1:0] v);
        expQ.push_back(v);
        nameQ.push_back(name);
    endtask

    // Present an op, hold it through any stall, and release it after the accepting edge
    task automatic issue(input logic alu, input logic mul, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b, output int stalls);
        @(negedge clk);
        ALUOp = alu; MULOp = mul; Func = f; A = a; B = b;
        stalls = 0;
        #1;
        while (Stall && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 200) begin
            checkCnt++;
            $display("FAIL stall_timeout: got Stall=1 after %0d cycles, expected release", stalls);
        end
        @(posedge clk);
        #1;
        ALUOp = 1'b0; MULOp = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ResValid) begin
            if (expQ.size() == 0) begin
                checkCnt++;
                $display("FAIL spurious_resvalid: got Res=0x%0h, expected no result", Res);
            end else begin
                monExp  = expQ.pop_front();
                monName = nameQ.pop_front();
                check(monName, {32'h0, Res}, {32'h0, monExp});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ALUOp = 1'b0; MULOp = 1'b0; Func = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);
        check("reset_res", Res, 0);
        check("reset_resvalid", ResValid, 0);
        check("reset_stall", Stall, 0);

        // Signed MULT with a following MFLO held off by Stall
        issue(1, 0, F_MULT, 32'hFFFF_FFFD, 32'd7, s);
        expectRes("t1_mflo", 32'hFFFF_FFEB);
        issue(1, 0, F_MFLO, 0, 0, s);
        check("t1_stall_cycles", s, W + 1);
        check("t1_hi_port", HI, 32'hFFFF_FFFF);
        expectRes("t1_mfhi", 32'hFFFF_FFFF);
        issue(1, 0, F_MFHI, 0, 0, s);

        // MTHI/MTLO then accumulate and subtract
        issue(1, 0, F_MTHI, 32'd0, 0, s);
        issue(1, 0, F_MTLO, 32'd10, 0, s);
        issue(0, 1, F_MADD, 32'd4, 32'd5, s);
        expectRes("t2_madd_lo", 32'd30);
        issue(1, 0, F_MFLO, 0, 0, s);
        check("t2_madd_stall_cycles", s, W + 2);
        expectRes("t2_madd_hi", 32'd0);
        issue(1, 0, F_MFHI, 0, 0, s);
        issue(0, 1, F_MSUB, 32'd32, 32'd1, s);
        expectRes("t2_msub_lo", 32'hFFFF_FFFE);
        issue(1, 0, F_MFLO, 0, 0, s);
        expectRes("t2_msub_hi", 32'hFFFF_FFFF);
        issue(1, 0, F_MFHI, 0, 0, s);

        // MUL writes only Res; HI/LO keep the MSUB result
        expectRes("t3_mul_res", 32'h0);
        issue(0, 1, F_MUL, 32'h0001_0000, 32'h0001_0000, s);
        expectRes("t3_mul_neg", 32'hFFFF_FFD6);
        issue(0, 1, F_MUL, 32'd7, 32'hFFFF_FFFA, s);
        expectRes("t3_hi_kept", 32'hFFFF_FFFF);
        issue(1, 0, F_MFHI, 0, 0, s);
        expectRes("t3_lo_kept", 32'hFFFF_FFFE);
        issue(1, 0, F_MFLO, 0, 0, s);

        // Unsigned max squared; unrelated ops pass during the run
        issue(1, 0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ALUOp = 1'b1; Func = F_ADD; A = 32'd1; B = 32'd2;
            #1 check("t4_add_no_stall", Stall, 0);
        end
`ifndef HILO_DIV_EN
        @(negedge clk);
        ALUOp = 1'b1; Func = F_DIV;
        #1 check("t4_div_ignored_no_stall", Stall, 0);
`endif
        @(negedge clk);
        ALUOp = 1'b0;
        expectRes("t4_multu_hi", 32'hFFFF_FFFE);
        issue(1, 0, F_MFHI, 0, 0, s);
        expectRes("t4_multu_lo", 32'h1);
        issue(1, 0, F_MFLO, 0, 0, s);

        // Most-negative operands, signed
        issue(1, 0, F_MULT, 32'h8000_0000, 32'h8000_0000, s);
        expectRes("edge_mult_hi", 32'h4000_0000);
        issue(1, 0, F_MFHI, 0, 0, s);
        expectRes("edge_mult_lo", 32'h0);
        issue(1, 0, F_MFLO, 0, 0, s);

`ifndef HILO_DIV_EN
        issue(1, 0, F_DIVU, 32'd9, 32'd3, s);
        expectRes("nodiv_lo_unchanged", 32'h0);
        issue(1, 0, F_MFLO, 0, 0, s);
`endif

        // Reset in the middle of an iteration with an MFHI held by Stall
        issue(1, 0, F_MULT, 32'd5, 32'd5, s);
        repeat (10) @(posedge clk);
        @(negedge clk);
        ALUOp = 1'b1; Func = F_MFHI;
        #1 check("t5_stall_before_rst", Stall, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_hi", HI, 0);
        check("t5_lo", LO, 0);
        check("t5_resvalid", ResValid, 0);
        check("t5_stall", Stall, 0);
        expectRes("t5_mfhi_after_rst", 32'h0);
        @(posedge clk);
        #1 ALUOp = 1'b0;

`ifdef HILO_DIV_EN
        issue(1, 0, F_DIV, 32'hFFFF_FFF9, 32'd2, s);
        expectRes("t6_div_lo", 32'hFFFF_FFFD);
        issue(1, 0, F_MFLO, 0, 0, s);
        check("t6_div_stall_cycles", s, W);
        expectRes("t6_div_hi", 32'hFFFF_FFFF);
        issue(1, 0, F_MFHI, 0, 0, s);
        issue(1, 0, F_DIVU, 32'd9, 32'd0, s);
        expectRes("t6_divz_lo", 32'hFFFF_FFFF);
        issue(1, 0, F_MFLO, 0, 0, s);
        expectRes("t6_divz_hi", 32'd9);
        issue(1, 0, F_MFHI, 0, 0, s);
        issue(1, 0, F_DIVU, 32'd100, 32'd7, s);
        expectRes("t6_divu_lo", 32'd14);
        issue(1, 0, F_MFLO, 0, 0, s);
        expectRes("t6_divu_hi", 32'd2);
        issue(1, 0, F_MFHI, 0, 0, s);
`endif

        repeat (5) @(posedge clk);
        check("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
